// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the HI/LO pair: mult/multu/div/divu take a fixed
// number of busy cycles, mthi/mtlo write in one edge. Define MULDIV_MADD_EN for madd/msub (ops 6/7).
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] pend_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q;
`ifdef MULDIV_MADD_EN
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;
  acc_t               acc_q;
`endif

  logic [2*WIDTH-1:0] smul_d, umul_d, sdiv_d, udiv_d, result_d;
  logic [WIDTH-1:0]   mag1_d, mag2_d, den_d, mq_d, mr_d, uq_d, ur_d, one_d;
  logic               div_zero_d;

  // Signed divide runs on magnitudes, so most-negative / -1 needs no special case
  // and never hits a two's-complement overflow in the divider itself.
  always_comb begin
    one_d      = {{(WIDTH-1){1'b0}}, 1'b1};
    smul_d     = $signed({{WIDTH{src1[WIDTH-1]}}, src1}) * $signed({{WIDTH{src2[WIDTH-1]}}, src2});
    umul_d     = {{WIDTH{1'b0}}, src1} * {{WIDTH{1'b0}}, src2};
    div_zero_d = (src2 == '0);
    mag1_d     = src1[WIDTH-1] ? -src1 : src1;
    mag2_d     = div_zero_d ? one_d : (src2[WIDTH-1] ? -src2 : src2);
    den_d      = div_zero_d ? one_d : src2;
    mq_d       = mag1_d / mag2_d;
    mr_d       = mag1_d % mag2_d;
    uq_d       = src1 / den_d;
    ur_d       = src1 % den_d;
    sdiv_d     = {(src1[WIDTH-1] ? -mr_d : mr_d),
                  ((src1[WIDTH-1] ^ src2[WIDTH-1]) ? -mq_d : mq_d)};
    udiv_d     = {ur_d, uq_d};
    if (div_zero_d) begin
      sdiv_d = {src1, {WIDTH{1'b1}}};
      udiv_d = {src1, {WIDTH{1'b1}}};
    end
    case (op)
      OP_MULT:  result_d = smul_d;
      OP_MULTU: result_d = umul_d;
      OP_DIV:   result_d = sdiv_d;
      OP_DIVU:  result_d = udiv_d;
      default:  result_d = smul_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_q <= S_BUSY;
                busy_q  <= 1'b1;
                cnt_q   <= (op == OP_MULT || op == OP_MULTU) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                pend_q  <= result_d;
`ifdef MULDIV_MADD_EN
                acc_q   <= ACC_NONE;
`endif
              end
              OP_MTHI: hi_q <= src1;
              OP_MTLO: lo_q <= src1;
`ifdef MULDIV_MADD_EN
              OP_MADD, OP_MSUB: begin
                state_q <= S_BUSY;
                busy_q  <= 1'b1;
                cnt_q   <= CW'(MUL_CYCLES);
                pend_q  <= smul_d;
                acc_q   <= (op == OP_MADD) ? ACC_ADD : ACC_SUB;
              end
`endif
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pend_q  <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef MULDIV_MADD_EN
            // Accumulate against HI/LO as they stand at completion, not at accept.
            case (acc_q)
              ACC_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
              ACC_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - pend_q;
              default: {hi_q, lo_q} <= pend_q;
            endcase
`else
            {hi_q, lo_q} <= pend_q;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at default parameters (WIDTH=32, MUL=5, DIV=10).
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          failures = 0;
  int          n;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the strobe is dropped after one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    issue(o, a, b);
    wait_idle(c);
    check({tag, "_cycles"}, 64'(c), 64'(exp_n));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    reset = 1'b1;

    run("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_zero", 3'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    run("div_zero", 3'd2, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

    // mtlo then mthi on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 3'd5; src1 = 32'h1234;
    @(negedge clk);
    check("mtlo_busy", 64'(busy), 64'h0);
    check("mtlo_lo", 64'(lo), 64'h1234);
    op = 3'd4; src1 = 32'hABCD;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy", 64'(busy), 64'h0);
    check("mthi_hi", 64'(hi), 64'hABCD);
    check("mthi_lo", 64'(lo), 64'h1234);

    run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

    // preload and cancel at busy cycle 4
    issue(3'd4, 32'd1, 32'd0);
    issue(3'd5, 32'd2, 32'd0);
    check("pre_hi", 64'(hi), 64'h1);
    check("pre_lo", 64'(lo), 64'h2);
    issue(3'd2, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    check("cancel_pre_busy", 64'(busy), 64'h1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'h0);
    check("cancel_hi", 64'(hi), 64'h1);
    check("cancel_lo", 64'(lo), 64'h2);
    repeat (12) @(negedge clk);
    check("cancel_late_hi", 64'(hi), 64'h1);
    check("cancel_late_lo", 64'(lo), 64'h2);

    // cancel coinciding with the completion edge
    issue(3'd0, 32'd7, 32'd9);
    repeat (4) @(negedge clk);
    check("cancel_last_pre_busy", 64'(busy), 64'h1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_last_busy", 64'(busy), 64'h0);
    check("cancel_last_hi", 64'(hi), 64'h1);
    check("cancel_last_lo", 64'(lo), 64'h2);
    repeat (3) @(negedge clk);
    check("cancel_last_late_lo", 64'(lo), 64'h2);

    // cancel alongside start in IDLE suppresses the op
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'd4; src1 = 32'h99;
    @(negedge clk);
    op = 3'd0; src1 = 32'd2; src2 = 32'd2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle_hi", 64'(hi), 64'h1);
    check("cancel_idle_busy", 64'(busy), 64'h0);

    // start while busy is ignored
    issue(3'd0, 32'd2, 32'd3);
    start = 1'b1; op = 3'd4; src1 = 32'h55;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    check("busy_start_cycles", 64'(n), 64'd4);
    check("busy_start_hi", 64'(hi), 64'h0);
    check("busy_start_lo", 64'(lo), 64'h6);

`ifdef MULDIV_MADD_EN
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd10, 32'd0);
    run("madd", 3'd6, 32'd3, 32'd4, 5, 32'h0, 32'd22);
    run("msub", 3'd7, 32'd5, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    issue(3'd6, 32'd5, 32'd5);
    check("rsv6_busy", 64'(busy), 64'h0);
    check("rsv6_lo", 64'(lo), 64'h6);
    issue(3'd7, 32'd5, 32'd5);
    check("rsv7_busy", 64'(busy), 64'h0);
    check("rsv7_hi", 64'(hi), 64'h0);
`endif

    // asynchronous reset in the middle of a multiply
    issue(3'd0, 32'd3, 32'd3);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    run("post_rst_multu", 3'd1, 32'd5, 32'd6, 5, 32'h0, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised successor to the pipeline's fixed 32-bit multiply/divide unit; sits in the E stage beside the ALU.
- Owns the HI/LO register pair and executes mult/multu/div/divu/mthi/mtlo.
- Adds configurable operand width and per-operation latency, a cancel input for exception flush, and defined divide-by-zero and overflow results.
- The stall controller stalls D-stage md instructions while start or busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=8)
MUL_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
start  input  1  issue strobe, one cycle, valid with op
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved (see Optional Feature)
src1  input  WIDTH  rs operand
src2  input  WIDTH  rt operand
cancel  input  1  exception flush of the in-flight op
busy  output  1  operation in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, counter=0, state IDLE. Reset while BUSY aborts the op immediately.
- States:
  - IDLE: start && !cancel && op in {0..3} -> BUSY; counter loaded with MUL_CYCLES or DIV_CYCLES; the 2*WIDTH result is computed and held in a pending register at the accept edge.
  - BUSY: counter decrements each edge. At the edge where counter reaches 1, {hi,lo} <= pending and the state returns to IDLE.
- Timing: start accepted at edge T0 -> busy=1 for exactly N cycles after T0. New hi/lo and busy=0 are both visible after edge T0+N.
- mthi/mtlo: in IDLE with start=1, hi (or lo) <= src1 at the next edge. No busy; the other register is unchanged.
- start while BUSY: ignored (the controller guarantees it does not occur). hi/lo and counter are unaffected.
- cancel:
  - In BUSY: state -> IDLE at the next edge, busy=0, pending discarded, hi/lo keep their pre-op values.
  - With start in IDLE: the start is ignored, including mthi/mtlo.
  - cancel and counter==1 in the same cycle: cancel wins, no write.
- Reserved ops 6/7 with the feature disabled: treated as a NOP, no busy.
- mult: signed WIDTH x WIDTH -> 2*WIDTH product; hi = upper half, lo = lower half. multu: unsigned.
- div: quotient truncates toward zero -> lo. Remainder takes the dividend's sign -> hi.
- divu: unsigned quotient -> lo, remainder -> hi.
- Divide by zero (both div and divu): lo = all ones, hi = src1. Full latency still applies.
- Signed overflow (src1 = most-negative value, src2 = -1): lo = most-negative value, hi = 0.
- hi/lo change only at a completion edge, an mthi/mtlo edge, or reset.

Optional Feature:
- Macro MULDIV_MADD_EN.
- Defined: op 6 = madd, op 7 = msub, signed, latency MUL_CYCLES.
  - At completion, {hi,lo} <= {hi,lo} ± src1*src2 (mod 2^(2*WIDTH)).
  - The accumulator value is sampled at completion, not at accept.
  - cancel leaves hi/lo untouched.
- Undefined: ops 6/7 are a NOP with no busy, per Behaviour.

Test Plan:
- Reset, then mult src1=0xFFFFFFFE (-2), src2=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- multu src1=0xFFFFFFFF, src2=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div src1=-7 (0xFFFFFFF9), src2=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, divu 7/0 -> lo=0xFFFFFFFF, hi=7.
- mtlo 0x1234 then mthi 0xABCD on consecutive cycles -> lo=0x1234, hi=0xABCD, busy never asserted. Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=1, lo=2; start div 100/3; assert cancel at busy cycle 4 -> busy=0 the next cycle, hi=1, lo=2 unchanged. Also pulse reset=0 mid-mult -> hi=lo=0, busy=0 asynchronously.
- With MULDIV_MADD_EN: hi=0, lo=10; madd 3*4 -> lo=22, hi=0; msub 5*5 -> {hi,lo}=0xFFFFFFFF_FFFFFFFD.
